im_access_arb: RTL

- Single-port access controller for the instruction memory.
- Shares the IM between two requesters:
  - the CPU fetch stage (read only);
  - the program loader/debug port (write).
- Sequences boot: the loader has exclusive ownership until loading completes, then fetch gets priority with starvation-bounded loader access.
- Sits between the fetch stage, the loader, and the IM word array; does the base-address translation and the range check.

---
 rtl/im_access_arb_if.sv | 40 ++++
 rtl/im_access_arb.sv | 86 ++++++++
 2 files changed

// File: rtl/im_access_arb_if.sv
// Signal bundle between the instruction-memory access arbiter, its two requesters
// (fetch and loader) and the IM word array.
interface im_access_arb_if #(
    parameter int ARCH_WIDTH = 32,
    parameter int IM_WIDTH   = 32,
    parameter int IM_DEPTH   = 10
);
    logic                  fetch_req;
    logic [ARCH_WIDTH-1:0] fetch_addr;
    logic                  fetch_gnt;
    logic                  fetch_rvalid;
    logic [IM_WIDTH-1:0]   fetch_rdata;
    logic                  fetch_err;

    logic                  ld_req;
    logic [ARCH_WIDTH-1:0] ld_addr;
    logic [IM_WIDTH-1:0]   ld_wdata;
    logic                  ld_gnt;
    logic                  ld_err;
    logic                  ld_done;

    logic                  running;

    logic [IM_DEPTH-1:0]   im_idx;
    logic                  im_we;
    logic [IM_WIDTH-1:0]   im_wdata;
    logic [IM_WIDTH-1:0]   im_rdata;

    modport slave (
        input  fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, ld_done, im_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
        output ld_gnt, ld_err, running, im_idx, im_we, im_wdata
    );

    modport master (
        output fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, ld_done, im_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
        input  ld_gnt, ld_err, running, im_idx, im_we, im_wdata
    );
endinterface

// File: rtl/im_access_arb.sv
// Single-port IM arbiter: loader owns the IM during boot, then fetch has priority
// with a starvation bound that periodically forces a pending loader write through.
module im_access_arb #(
    parameter int                    ARCH_WIDTH   = 32,
    parameter int                    IM_WIDTH     = 32,
    parameter int                    IM_DEPTH     = 10,
    parameter logic [ARCH_WIDTH-1:0] IM_BASE_ADDR = 32'h0000_3000,
    parameter int                    STARVE_MAX   = 4
) (
    input  logic            clk,
    input  logic            rst,
    im_access_arb_if.slave  bus
);
    typedef enum logic {BOOT, RUN} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t                state;
    logic [3:0]            starve_cnt;
    logic [ARCH_WIDTH-1:0] f_off;
    logic [ARCH_WIDTH-1:0] l_off;
    logic                  f_bad;
    logic                  l_bad;
    logic [IM_DEPTH-1:0]   f_idx;
    logic [IM_DEPTH-1:0]   l_idx;
    logic                  fetch_gnt;
    logic                  ld_gnt;

    // Underflow below the base wraps to a huge offset, which the upper-bit test rejects.
    assign f_off = bus.fetch_addr - IM_BASE_ADDR;
    assign l_off = bus.ld_addr - IM_BASE_ADDR;
    assign f_idx = f_off[IM_DEPTH+1:2];
    assign l_idx = l_off[IM_DEPTH+1:2];
    assign f_bad = (f_off[1:0] != 2'b00) || (f_off[ARCH_WIDTH-1:IM_DEPTH+2] != '0);
    assign l_bad = (l_off[1:0] != 2'b00) || (l_off[ARCH_WIDTH-1:IM_DEPTH+2] != '0);

    always_comb begin
        ld_gnt    = 1'b0;
        fetch_gnt = 1'b0;
        if (!rst) begin
            if (state == BOOT) begin
                ld_gnt = bus.ld_req;
            end else begin
                ld_gnt    = bus.ld_req & (~bus.fetch_req | (starve_cnt == STARVE_LIM));
                fetch_gnt = bus.fetch_req & ~ld_gnt;
            end
        end
    end

    assign bus.ld_gnt    = ld_gnt;
    assign bus.fetch_gnt = fetch_gnt;
    assign bus.im_we     = ld_gnt & ~l_bad;
    assign bus.im_wdata  = bus.ld_wdata;
    assign bus.im_idx    = ld_gnt ? l_idx : (fetch_gnt ? f_idx : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= BOOT;
            starve_cnt       <= 4'd0;
            bus.fetch_rvalid <= 1'b0;
            bus.fetch_rdata  <= '0;
            bus.fetch_err    <= 1'b0;
            bus.ld_err       <= 1'b0;
            bus.running      <= 1'b0;
        end else begin
            if (state == BOOT && bus.ld_done) begin
                state       <= RUN;
                bus.running <= 1'b1;
            end

            if (ld_gnt) begin
                starve_cnt <= 4'd0;
            end else if (bus.ld_req && fetch_gnt && starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            bus.fetch_rvalid <= fetch_gnt;
            if (fetch_gnt) begin
                bus.fetch_rdata <= f_bad ? '0 : bus.im_rdata;
                bus.fetch_err   <= f_bad;
            end

            bus.ld_err <= ld_gnt & l_bad;
        end
    end
endmodule
